uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 8: transmit FIFO depth in bytes, power of two, 2..64.
REQ-002 Parameter DIV_W, default 16: width of the baud divisor input.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port div  input  DIV_W  bit period minus one, in clk cycles.
REQ-006 Port tx_data  input  8  byte to enqueue.
REQ-007 Port tx_valid  input  1  tx_data valid.
REQ-008 Port tx_ready  output  1  FIFO can accept a byte.
REQ-009 Port tx  output  1  serial line to pad (io[30]); idle high.
REQ-010 Port busy  output  1  FIFO non-empty or frame in progress.
REQ-011 Port level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-012 The block SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1.
REQ-013 Every bit SHALL last exactly div+1 clk cycles; div=0 gives 1 cycle per bit.
REQ-014 div SHALL be latched at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-015 tx_ready SHALL equal (level != DEPTH), combinationally from registered state.
REQ-016 A push SHALL occur on an edge where tx_valid && tx_ready; tx_valid while full SHALL be ignored, no data lost or overwritten.
REQ-017 The state machine SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE -> START on the first edge with level != 0; the FIFO head SHALL be popped on that same edge.
REQ-019 START -> DATA after one bit period; DATA -> STOP after 8 bit periods, with a 3-bit bit index wrapping 7 -> 0.
REQ-020 STOP -> START directly, with no idle cycle, if level != 0 at the end of the stop bit (pop on that edge); otherwise STOP -> IDLE.
REQ-021 tx SHALL be a registered output driven low from the START-entry edge; there SHALL be no glitches between bits.
REQ-022 Latency: a push into an empty FIFO in IDLE at edge N SHALL produce tx low after edge N+1.
REQ-023 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL distinguish full from empty.
REQ-025 busy SHALL equal (state != IDLE) || (level != 0).

Reset
REQ-026 While rst is high at an edge: state = IDLE, tx = 1, level = 0, pointers = 0, tx_ready = 1 and busy = 0 after that edge.
REQ-027 Reset mid-frame SHALL abort the frame immediately: tx returns high after the reset edge and FIFO contents are discarded.
REQ-028 FIFO storage SHALL NOT require reset.

Verification
REQ-029 div=3, push 0x55 at edge N -> tx low over edges N+1..N+4, then 1,0,1,0,1,0,1,0 for 4 cycles each, stop high for 4 cycles; busy falls after edge N+41.
REQ-030 div=0, push 0xA3 and 0x0F back-to-back -> 20 consecutive bit cycles 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1 with no idle gap.
REQ-031 Hold tx_valid for 10 cycles while tx is stalled by div=1000 -> tx_ready low once level=8; exactly 9 bytes accepted (one popped at frame start); all transmitted in order.
REQ-032 Assert rst during DATA bit 4 -> tx=1, level=0, busy=0 after the reset edge; a new push afterwards transmits correctly.
REQ-033 div changed from 3 to 7 mid-frame -> current frame stays at 4 cycles/bit; the next frame uses 8 cycles/bit.
REQ-034 Push on the pop edge with level=1 -> level stays 1 and the pushed byte is sent in the next frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO.
// The divisor is captured when each frame starts, so the line rate can change between frames.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIV_W-1:0]         div,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [7:0]       mem [DEPTH];
  logic             push, pop, bit_end, fifo_nonempty;

  assign fifo_nonempty = (level != '0);
  assign tx_ready      = (level != LW'(DEPTH));
  assign push          = tx_valid && tx_ready;
  assign bit_end       = (cnt_q == div_q);
  assign busy          = (state_q != IDLE) || fifo_nonempty;
  assign tx            = tx_q;

  // Next-state and next-line logic; a pop always begins a fresh frame with a start bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = 3'd0;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          sh_d  = {1'b0, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      sh_d  = mem[rd_ptr];
      div_d = div;
      cnt_d = '0;
      tx_d  = 1'b0;
    end
  end

  // State, frame and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Storage is left unreset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame tables, corner sequences, and random traffic
// compared each cycle against a queue-based line model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx;
  logic             busy;
  logic [LW-1:0]    level;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .div(div), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Line model: a queue of waiting bytes plus the frame on the wire, with the
  // line value taken as bit (elapsed / cycles-per-bit) of {stop, data, start}.
  byte unsigned mq[$];
  bit           m_act = 1'b0;
  int           m_el  = 0;
  int           m_div = 0;
  logic [9:0]   m_fr  = '1;
  bit           m_push, m_end;
  logic [7:0]   m_b;
  logic         m_tx;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
      m_el  = 0;
    end else begin
      m_push = tx_valid && (mq.size() < DEPTH);
      m_end  = m_act && (m_el == 10 * (m_div + 1) - 1);
      if ((!m_act || m_end) && mq.size() != 0) begin
        m_b   = mq.pop_front();
        m_fr  = {1'b1, m_b, 1'b0};
        m_div = int'(div);
        m_el  = 0;
        m_act = 1'b1;
      end else if (m_end) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_el++;
      end
      if (m_push) mq.push_back(tx_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_tx = m_act ? m_fr[m_el / (m_div + 1)] : 1'b1;
      chk("model_tx", 32'(tx), 32'(m_tx));
      chk("model_level", 32'(level), 32'(mq.size()));
      chk("model_ready", 32'(tx_ready), 32'(mq.size() != DEPTH));
      chk("model_busy", 32'(busy), 32'(m_act || mq.size() != 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 32'(busy), 32'(0));
  endtask

  typedef struct {
    logic [15:0] d;
    logic [7:0]  data;
    logic [9:0]  frame;
  } vec_t;

  vec_t       vt[5];
  logic [19:0] exp20;
  int          acc;

  initial begin
    // Frame bits listed LSB = first on the wire.
    vt[0] = '{d: 16'd3, data: 8'h55, frame: 10'b1010101010};
    vt[1] = '{d: 16'd0, data: 8'hA3, frame: 10'b1101000110};
    vt[2] = '{d: 16'd0, data: 8'h0F, frame: 10'b1000011110};
    vt[3] = '{d: 16'd1, data: 8'h00, frame: 10'b1000000000};
    vt[4] = '{d: 16'd2, data: 8'hFF, frame: 10'b1111111110};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; div = 16'd3;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(tx_ready), 32'(1));

    // Single-frame table.
    foreach (vt[i]) begin
      div = vt[i].d; tx_valid = 1'b1; tx_data = vt[i].data;
      tick(1);
      tx_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c <= int'(vt[i].d); c++) begin
          tick(1);
          chk("vec_bit", 32'(tx), 32'(vt[i].frame[k]));
        end
      end
      chk("vec_busy_stop", 32'(busy), 32'(1));
      tick(1);
      chk("vec_busy_fall", 32'(busy), 32'(0));
      chk("vec_idle_tx", 32'(tx), 32'(1));
    end

    // Back-to-back at one cycle per bit; second push lands on the pop edge.
    exp20 = {10'b1000011110, 10'b1101000110};
    div = 16'd0; tx_valid = 1'b1; tx_data = 8'hA3;
    tick(1);
    tx_data = 8'h0F;
    tick(1);
    tx_valid = 1'b0;
    chk("pushpop_level", 32'(level), 32'(1));
    chk("b2b_bit0", 32'(tx), 32'(exp20[0]));
    for (int k = 1; k < 20; k++) begin
      tick(1);
      chk("b2b_bit", 32'(tx), 32'(exp20[k]));
    end
    wait_idle(10);

    // Stall with a long divisor and hold tx_valid for 10 cycles.
    div = 16'd1000; acc = 0;
    for (int i = 0; i < 10; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h10 + i);
      if (tx_ready) acc++;
      tick(1);
    end
    tx_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'(9));
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_ready", 32'(tx_ready), 32'(0));
    div = 16'd1;
    wait_idle(12000);

    // Reset during data bit 4.
    div = 16'd3; tx_valid = 1'b1; tx_data = 8'h3C;
    tick(1);
    tx_valid = 1'b0;
    tick(21);
    chk("rst_mid_bit4", 32'(tx), 32'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_tx", 32'(tx), 32'(1));
    chk("rst_mid_level", 32'(level), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_ready", 32'(tx_ready), 32'(1));
    tx_valid = 1'b1; tx_data = 8'h96;
    tick(1);
    tx_valid = 1'b0;
    wait_idle(100);

    // Divisor change mid-frame applies only to the next frame.
    div = 16'd3; tx_valid = 1'b1; tx_data = 8'h81;
    tick(1);
    tx_data = 8'h43;
    tick(1);
    tx_valid = 1'b0;
    chk("div_start", 32'(tx), 32'(0));
    tick(3);
    chk("div_start_end", 32'(tx), 32'(0));
    tick(1);
    chk("div_d0", 32'(tx), 32'(1));
    div = 16'd7;
    tick(35);
    chk("div_stop", 32'(tx), 32'(1));
    tick(1);
    chk("div2_start", 32'(tx), 32'(0));
    tick(7);
    chk("div2_start_end", 32'(tx), 32'(0));
    tick(1);
    chk("div2_d0", 32'(tx), 32'(1));
    wait_idle(200);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom % 4 == 0);
      tx_data  = 8'($urandom);
      if ($urandom % 200 == 0) div = 16'($urandom_range(0, 3));
      rst = ($urandom % 1500 == 0);
      tick(1);
    end
    rst = 1'b0; tx_valid = 1'b0;
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
